// File: rtl/if_prefetch_stage.sv
// Instruction fetch stage with a DEPTH-entry prefetch queue in front of a
// one-cycle-latency synchronous instruction memory; supports branch redirect.
module if_prefetch_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       Branch_taken,
  input  logic [ADDR_W-1:0]          BranchAddr,
  output logic                       imem_en,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_CREDIT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT    = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] r_fetchPc;
  logic [ADDR_W-1:0] r_inflightAddr;
  logic              r_inflight;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_instrQ [DEPTH];
  logic [ADDR_W-1:0] r_pcQ    [DEPTH];

  logic [CNT_W:0]    w_credit;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  // Credit counts queued entries plus the outstanding request, so a response
  // always finds a free slot; a pop in the same cycle is deliberately ignored.
  assign w_credit  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_issue   = !rst && !Branch_taken && (w_credit < DEPTH_CREDIT);
  assign w_push    = r_inflight && !rst && !Branch_taken;
  assign w_pop     = out_valid && !freeze;

  assign imem_en   = w_issue;
  assign imem_addr = r_fetchPc;
  assign out_valid = (r_count != '0) && !rst;
  assign occupancy = rst ? '0 : r_count;
  assign out_instr = r_instrQ[r_head];
  assign out_pc    = r_pcQ[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc      <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflightAddr <= '0;
      r_head         <= '0;
      r_tail         <= '0;
      r_count        <= '0;
    end else if (Branch_taken) begin
      r_fetchPc  <= {BranchAddr[ADDR_W-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetchPc      <= r_fetchPc + ADDR_W'(4);
        r_inflightAddr <= r_fetchPc;
      end
      if (w_push) r_tail <= r_tail + PTR_W'(1);
      if (w_pop)  r_head <= r_head + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage carries no reset; validity is tracked by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instrQ[r_tail] <= imem_rdata;
      r_pcQ[r_tail]    <= r_inflightAddr + ADDR_W'(4);
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_push && !w_pop && (r_count == DEPTH_CNT)));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Scoreboard bench for if_prefetch_stage: a spec-level model predicts request
// addresses, queue contents and output timing every cycle.
module tb_if_prefetch_stage;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] BranchAddr = '0;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;

  int nCompared = 0;
  int nMismatched = 0;
  int reqCount = 0;

  entry_t      q[$];
  entry_t      pendEntry;
  logic        pending = 1'b0;
  logic [31:0] expPc = RESET_PC;

  if_prefetch_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .Branch_taken(Branch_taken),
    .BranchAddr(BranchAddr), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] addr);
    return (addr >> 2) + 32'd100;
  endfunction

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memWord(imem_addr);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scoreboard: each issued request queues its expected entry, which becomes
  // visible two cycles later unless a redirect or reset intervenes.
  always @(negedge clk) begin
    logic expValid;
    logic expEn;
    expValid = (q.size() != 0) && !rst;
    expEn = !rst && !Branch_taken && ((q.size() + int'(pending)) < DEPTH);
    checkOutput("out_valid", {31'b0, out_valid}, {31'b0, expValid});
    checkOutput("occupancy", {29'b0, occupancy}, rst ? 32'd0 : q.size());
    checkOutput("imem_en", {31'b0, imem_en}, {31'b0, expEn});
    if (expValid && out_valid) begin
      checkOutput("out_instr", out_instr, q[0].instr);
      checkOutput("out_pc", out_pc, q[0].pc);
    end
    if (rst) begin
      q.delete();
      pending = 1'b0;
      expPc = RESET_PC;
    end else if (Branch_taken) begin
      q.delete();
      pending = 1'b0;
      expPc = BranchAddr & 32'hFFFF_FFFC;
    end else begin
      if (q.size() != 0 && !freeze) void'(q.pop_front());
      if (pending) q.push_back(pendEntry);
      pending = imem_en;
      if (imem_en) begin
        checkOutput("imem_addr", imem_addr, expPc);
        pendEntry.instr = memWord(expPc);
        pendEntry.pc = expPc + 32'd4;
        expPc = expPc + 32'd4;
        reqCount++;
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic f, input logic b, input logic [31:0] a);
    @(posedge clk);
    #1;
    rst = r;
    freeze = f;
    Branch_taken = b;
    BranchAddr = a;
  endtask

  task automatic waitSample();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Cold start and free-running fetch.
    repeat (3) applyStimulus(1, 0, 0, 0);
    repeat (8) applyStimulus(0, 0, 0, 0);

    // Freeze from cold start: queue fills to DEPTH and fetching stops.
    applyStimulus(1, 1, 0, 0);
    reqCount = 0;
    repeat (10) applyStimulus(0, 1, 0, 0);
    waitSample();
    checkOutput("freeze_reqs", reqCount, 32'd4);
    checkOutput("freeze_occ", {29'b0, occupancy}, 32'd4);
    checkOutput("freeze_head_pc", out_pc, 32'd4);
    checkOutput("freeze_head_instr", out_instr, 32'd100);
    repeat (8) applyStimulus(0, 0, 0, 0);

    // Redirect with two queued entries and one request in flight.
    applyStimulus(1, 1, 0, 0);
    repeat (3) applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 1, 32'h43);
    applyStimulus(0, 0, 0, 0);
    waitSample();
    checkOutput("redirect_occ", {29'b0, occupancy}, 32'd0);
    repeat (6) applyStimulus(0, 0, 0, 0);

    // Redirect coinciding with a pop, then back-to-back redirects.
    applyStimulus(0, 0, 1, 32'h200);
    repeat (5) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h300);
    applyStimulus(0, 0, 1, 32'h406);
    repeat (6) applyStimulus(0, 0, 0, 0);

    // Address wrap at the top of memory.
    applyStimulus(0, 0, 1, 32'hFFFF_FFF8);
    repeat (7) applyStimulus(0, 0, 0, 0);

    // Reset mid-stream with a nearly full queue and a request in flight.
    applyStimulus(0, 1, 1, 32'h80);
    repeat (4) applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    waitSample();
    checkOutput("post_reset_addr", imem_addr, RESET_PC);
    repeat (5) applyStimulus(0, 0, 0, 0);

    // Random freeze with occasional redirects.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0)
        applyStimulus(0, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 1023) * 4);
      else
        applyStimulus(0, 1'($urandom_range(0, 1)), 0, 0);
    end
    repeat (8) applyStimulus(0, 0, 0, 0);
    waitSample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
